// File: rtl/fetch_aligner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : fetch_aligner                                                  |
// | Purpose : Fetches 32-bit words from instruction memory and re-aligns     |
// |           them into a stream of 16-bit (compressed) and 32-bit           |
// |           instructions through a 4-entry halfword FIFO.                  |
// | Ports   : clk, arstn (async, active low)                                 |
// |           redirectEn/redirectPc  - flush and restart request             |
// |           imemReq/imemAddr/imemGnt - memory request channel              |
// |           imemRvalid/imemRdata     - in-order memory response channel    |
// |           instrValid/instrReady/instr/instrPc/instrCompressed - output   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module fetch_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        arstn,
  input  logic        redirectEn,
  input  logic [31:0] redirectPc,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemGnt,
  input  logic        imemRvalid,
  input  logic [31:0] imemRdata,
  output logic        instrValid,
  input  logic        instrReady,
  output logic [31:0] instr,
  output logic [31:0] instrPc,
  output logic        instrCompressed
);

  localparam int DEPTH = 4;

  logic [15:0] fifo_q [DEPTH];
  logic [15:0] fifo_d [DEPTH];
  logic [15:0] shifted [DEPTH];
  logic [2:0]  count_q, count_d, count_pop;
  logic [31:0] fetch_addr_q, fetch_addr_d;
  logic [31:0] pc_q, pc_d;
  logic        outstanding_q, outstanding_d;
  logic        discard_q, discard_d;
  logic        skip_low_q, skip_low_d;

  logic        entry0_comp;
  logic        avail;
  logic        xfer;
  logic        accept;
  logic [1:0]  pop_n;
  logic        unused_pc_bit0;

  assign unused_pc_bit0 = redirectPc[0];

  assign entry0_comp = (fifo_q[0][1:0] != 2'b11);
  // A full instruction with only its low half buffered waits for the next word.
  assign avail       = (count_q >= 3'd2) || ((count_q == 3'd1) && entry0_comp);

  assign instrValid      = !redirectEn && avail;
  assign instr           = !instrValid ? 32'h0 :
                           entry0_comp ? {16'h0, fifo_q[0]} : {fifo_q[1], fifo_q[0]};
  assign instrCompressed = instrValid && entry0_comp;
  assign instrPc         = pc_q;

  // Request only when a full word is guaranteed to fit after any pops.
  assign imemReq  = arstn && !outstanding_q && (count_q <= 3'd2) && !redirectEn;
  assign imemAddr = fetch_addr_q;

  assign xfer   = instrValid && instrReady;
  assign accept = imemReq && imemGnt;
  assign pop_n  = !xfer ? 2'd0 : (entry0_comp ? 2'd1 : 2'd2);

  always_comb begin
    // Pop first: shift the surviving halfwords down to entry 0.
    case (pop_n)
      2'd1:    shifted = '{fifo_q[1], fifo_q[2], fifo_q[3], 16'h0};
      2'd2:    shifted = '{fifo_q[2], fifo_q[3], 16'h0, 16'h0};
      default: shifted = fifo_q;
    endcase
    count_pop = count_q - {1'b0, pop_n};

    fifo_d        = shifted;
    count_d       = count_pop;
    fetch_addr_d  = fetch_addr_q;
    pc_d          = pc_q + {29'b0, pop_n, 1'b0};
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    skip_low_d    = skip_low_q;

    if (redirectEn) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_d[i] = 16'h0;
      end
      count_d      = 3'd0;
      fetch_addr_d = {redirectPc[31:2], 2'b00};
      pc_d         = {redirectPc[31:1], 1'b0};
      skip_low_d   = redirectPc[1];
      // A response arriving in the redirect cycle is dropped on the spot; a
      // transaction still in flight afterwards is stale and must be dropped
      // when it returns.
      outstanding_d = outstanding_q && !imemRvalid;
      discard_d     = outstanding_q && !imemRvalid;
    end else begin
      if (accept) begin
        outstanding_d = 1'b1;
        fetch_addr_d  = fetch_addr_q + 32'd4;
      end
      if (imemRvalid) begin
        outstanding_d = 1'b0;
        if (discard_q) begin
          discard_d = 1'b0;
        end else begin
          // Push after pop: write at the post-pop fill level.
          for (int i = 0; i < DEPTH; i++) begin
            if (count_pop == 3'(i)) begin
              fifo_d[i] = skip_low_q ? imemRdata[31:16] : imemRdata[15:0];
            end
            if (!skip_low_q && ((count_pop + 3'd1) == 3'(i))) begin
              fifo_d[i] = imemRdata[31:16];
            end
          end
          count_d    = count_pop + (skip_low_q ? 3'd1 : 3'd2);
          skip_low_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= 16'h0;
      end
      count_q       <= 3'd0;
      fetch_addr_q  <= {RESET_PC[31:2], 2'b00};
      pc_q          <= {RESET_PC[31:1], 1'b0};
      outstanding_q <= 1'b0;
      discard_q     <= 1'b0;
      skip_low_q    <= RESET_PC[1];
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= fifo_d[i];
      end
      count_q       <= count_d;
      fetch_addr_q  <= fetch_addr_d;
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      skip_low_q    <= skip_low_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_aligner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_fetch_aligner                                               |
// | Purpose : Self-checking bench for fetch_aligner. A memory model answers  |
// |           requests with random grant/latency; an instruction-stream      |
// |           model walks memory from the current PC and predicts every      |
// |           delivered instruction. Directed scenarios pin literal values.  |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_fetch_aligner;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        arstn = 1'b0;
  logic        redirectEn = 1'b0;
  logic [31:0] redirectPc = 32'h0;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemGnt = 1'b0;
  logic        imemRvalid = 1'b0;
  logic [31:0] imemRdata = 32'h0;
  logic        instrValid;
  logic        instrReady = 1'b0;
  logic [31:0] instr;
  logic [31:0] instrPc;
  logic        instrCompressed;

  fetch_aligner #(.RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .arstn           (arstn),
    .redirectEn      (redirectEn),
    .redirectPc      (redirectPc),
    .imemReq         (imemReq),
    .imemAddr        (imemAddr),
    .imemGnt         (imemGnt),
    .imemRvalid      (imemRvalid),
    .imemRdata       (imemRdata),
    .instrValid      (instrValid),
    .instrReady      (instrReady),
    .instr           (instr),
    .instrPc         (instrPc),
    .instrCompressed (instrCompressed)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int fails   = 0;

  // 1 KB instruction memory, address bits 9:2 select the word.
  logic [31:0] mem [256];

  bit          mem_busy;
  logic [31:0] mem_addr;
  int          mem_lat;
  int          lat_min = 1, lat_max = 1, gnt_pct = 100, rdy_pct = 100;

  logic [31:0] model_pc;
  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
    logic        c;
    int          cyc;
  } xfer_t;
  xfer_t       seen[$];
  logic [31:0] acc_q[$];
  int          cyc = 0;
  int          resp4_cyc = -1;
  bit          prev_hold = 1'b0;
  logic [31:0] prev_instr, prev_pc;
  int          stall_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] hw_at(input logic [31:0] a);
    logic [31:0] w;
    w = mem[a[9:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  // One clock cycle, entered and left at a falling edge.
  task automatic step(input bit do_redir, input logic [31:0] rpc);
    logic [15:0] h0;
    logic [31:0] exp_i;
    bit          exp_c, xfer, acc;
    imemRvalid = 1'b0;
    imemRdata  = $urandom();
    if (mem_busy) begin
      if (mem_lat <= 1) begin
        imemRvalid = 1'b1;
        imemRdata  = mem[mem_addr[9:2]];
        mem_busy   = 1'b0;
        if (mem_addr == 32'h4) resp4_cyc = cyc;
      end else begin
        mem_lat--;
      end
    end
    redirectEn = do_redir;
    redirectPc = rpc;
    instrReady = (int'($urandom_range(0, 99)) < rdy_pct);
    #1;
    imemGnt = (int'($urandom_range(0, 99)) < gnt_pct);
    #1;

    if (imemReq) check("imemAddr_aligned", {30'b0, imemAddr[1:0]}, 32'h0);
    if (do_redir) begin
      check("imemReq_in_redirect", 32'(imemReq), 32'h0);
      check("instrValid_in_redirect", 32'(instrValid), 32'h0);
    end
    acc = imemReq && imemGnt;
    if (acc) begin
      check("single_outstanding", 32'(mem_busy), 32'h0);
      mem_busy = 1'b1;
      mem_addr = imemAddr;
      mem_lat  = $urandom_range(lat_min, lat_max);
      acc_q.push_back(imemAddr);
    end

    if (prev_hold && !do_redir) begin
      check("hold_valid", 32'(instrValid), 32'h1);
      check("hold_instr", instr, prev_instr);
      check("hold_pc", instrPc, prev_pc);
    end

    xfer = instrValid && instrReady && !do_redir;
    if (xfer) begin
      h0    = hw_at(model_pc);
      exp_c = (h0[1:0] != 2'b11);
      exp_i = exp_c ? {16'h0, h0} : {hw_at(model_pc + 32'd2), h0};
      check("instr", instr, exp_i);
      check("instrPc", instrPc, model_pc);
      check("instrCompressed", 32'(instrCompressed), 32'(exp_c));
      seen.push_back('{instr, instrPc, instrCompressed, cyc});
      model_pc  = model_pc + (exp_c ? 32'd2 : 32'd4);
      stall_cnt = 0;
    end else if (instrReady && !do_redir) begin
      stall_cnt++;
      if (stall_cnt > 40) begin
        vectors++;
        fails++;
        $display("FAIL progress: %0d ready cycles without a transfer, limit 40", stall_cnt);
        stall_cnt = 0;
      end
    end

    if (do_redir) model_pc = {rpc[31:1], 1'b0};
    prev_hold  = instrValid && !instrReady && !do_redir;
    prev_instr = instr;
    prev_pc    = instrPc;
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) step(1'b0, 32'h0);
  endtask

  // Asynchronous reset; memory side is reset alongside.
  task automatic do_reset();
    arstn      = 1'b0;
    imemGnt    = 1'b0;
    imemRvalid = 1'b0;
    redirectEn = 1'b0;
    instrReady = 1'b0;
    mem_busy   = 1'b0;
    #1;
    check("rst_imemReq", 32'(imemReq), 32'h0);
    check("rst_instrValid", 32'(instrValid), 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_instrCompressed", 32'(instrCompressed), 32'h0);
    check("rst_imemAddr", imemAddr, {RESET_PC[31:2], 2'b00});
    check("rst_instrPc", instrPc, {RESET_PC[31:1], 1'b0});
    @(negedge clk);
    @(negedge clk);
    arstn     = 1'b1;
    model_pc  = {RESET_PC[31:1], 1'b0};
    prev_hold = 1'b0;
    stall_cnt = 0;
    resp4_cyc = -1;
    seen.delete();
    acc_q.delete();
    #1;
    check("imemReq_after_reset", 32'(imemReq), 32'h1);
  endtask

  task automatic check_seen(input string nm, input int idx, input logic [31:0] ei,
                            input logic [31:0] ep, input logic ec);
    if (seen.size() <= idx) begin
      vectors++;
      fails++;
      $display("FAIL %s: %0d transfers seen, required more than %0d", nm, seen.size(), idx);
    end else begin
      check({nm, "_instr"}, seen[idx].ins, ei);
      check({nm, "_pc"}, seen[idx].pc, ep);
      check({nm, "_compressed"}, 32'(seen[idx].c), 32'(ec));
    end
  endtask

  task automatic directed_knobs(input int lat, input int rdy);
    lat_min = lat;
    lat_max = lat;
    gnt_pct = 100;
    rdy_pct = rdy;
  endtask

  initial begin
    logic [31:0] rpc;
    int          r;
    for (int i = 0; i < 256; i++) mem[i] = $urandom();
    @(negedge clk);

    // Sequential full-width fetch.
    directed_knobs(1, 100);
    mem[0] = 32'h0000_0013;
    mem[1] = 32'h0010_0093;
    do_reset();
    run(10);
    check("seq_first_acc", (acc_q.size() > 0) ? acc_q[0] : 32'hFFFF_FFFF, RESET_PC);
    check_seen("seq0", 0, 32'h0000_0013, 32'h0, 1'b0);
    check_seen("seq1", 1, 32'h0010_0093, 32'h4, 1'b0);

    // Two compressed instructions in one word.
    mem[0] = 32'h0001_4501;
    do_reset();
    run(8);
    check_seen("cpair0", 0, 32'h0000_4501, 32'h0, 1'b1);
    check_seen("cpair1", 1, 32'h0000_0001, 32'h2, 1'b1);

    // Full instruction straddling two words, slow memory.
    directed_knobs(3, 100);
    mem[0] = 32'h0093_4501;
    mem[1] = 32'hABCD_0010;
    do_reset();
    run(14);
    check_seen("strad0", 0, 32'h0000_4501, 32'h0, 1'b1);
    check_seen("strad1", 1, 32'h0010_0093, 32'h2, 1'b0);
    check("strad_after_word1",
          32'((seen.size() > 1) && (resp4_cyc >= 0) && (seen[1].cyc > resp4_cyc)), 32'h1);

    // Redirect to an odd halfword while a response is outstanding.
    mem[0]  = 32'h0001_4501;
    mem[65] = 32'h1234_0001;
    mem[66] = 32'h0000_0013;
    do_reset();
    step(1'b0, 32'h0);
    step(1'b1, 32'h0000_0106);
    run(14);
    check("redir_acc0", (acc_q.size() > 0) ? acc_q[0] : 32'hFFFF_FFFF, 32'h0);
    check("redir_acc1", (acc_q.size() > 1) ? acc_q[1] : 32'hFFFF_FFFF, 32'h104);
    check_seen("redir0", 0, 32'h0000_1234, 32'h106, 1'b1);
    check_seen("redir1", 1, 32'h0000_0013, 32'h108, 1'b0);

    // Backpressure with a full FIFO.
    directed_knobs(1, 0);
    mem[0] = 32'h0000_0013;
    mem[1] = 32'h0010_0093;
    do_reset();
    run(10);
    repeat (5) begin
      check("bp_imemReq", 32'(imemReq), 32'h0);
      check("bp_instr", instr, 32'h0000_0013);
      check("bp_instrPc", instrPc, 32'h0);
      step(1'b0, 32'h0);
    end
    rdy_pct = 100;
    run(10);
    check_seen("bp0", 0, 32'h0000_0013, 32'h0, 1'b0);
    check_seen("bp1", 1, 32'h0010_0093, 32'h4, 1'b0);

    // Reset with buffered halfwords and a transaction in flight.
    directed_knobs(3, 0);
    mem[0] = 32'h0001_4501;
    do_reset();
    run(6);
    #3;
    do_reset();
    directed_knobs(1, 100);
    run(8);
    check("mrst_acc0", (acc_q.size() > 0) ? acc_q[0] : 32'hFFFF_FFFF, RESET_PC);
    check_seen("mrst0", 0, 32'h0000_4501, 32'h0, 1'b1);

    // Randomized traffic against the stream model.
    for (int i = 0; i < 256; i++) mem[i] = $urandom();
    lat_min = 1;
    lat_max = 3;
    gnt_pct = 70;
    rdy_pct = 75;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (n % 500 == 0) rdy_pct = int'($urandom_range(20, 100));
      r = int'($urandom_range(0, 299));
      if (r < 8) begin
        case ($urandom_range(0, 2))
          0:       rpc = $urandom();
          1:       rpc = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
          default: rpc = 32'($urandom_range(0, 1023));
        endcase
        step(1'b1, rpc);
      end else if (r == 8) begin
        #3;
        do_reset();
      end else begin
        step(1'b0, 32'h0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
